// File: rtl/fsm_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : fsm_event_monitor
// Purpose  : Decodes {o1,o2,err} of the control FSM, tracks IDLE->S1->S2->IDLE,
//            counts sequences/error entries, flags violations and illegal codes.
// Revision : 1.0
// ============================================================================
module fsm_event_monitor #(
    parameter int CNT_W     = 8,
    parameter int ERR_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fsm_o1,
    input  logic             fsm_o2,
    input  logic             fsm_err,
    input  logic             clr,
    output logic             seq_done,
    output logic             seq_viol,
    output logic [CNT_W-1:0] seq_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             alarm,
    output logic             illegal
);

    localparam logic [3:0] C_ERR_LIMIT = 4'(ERR_LIMIT);

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_S1   = 2'd1,
        T_S2   = 2'd2,
        T_ERR  = 2'd3
    } trk_e;

    trk_e             trk_q, trk_d;
    logic             prev_err_q;
    logic [3:0]       consec_q, consec_d;
    logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             alarm_q, alarm_d;
    logic             illegal_q, illegal_d;
    logic             seq_done_q, seq_done_d;
    logic             seq_viol_q, seq_viol_d;

    logic [2:0] w_code;
    logic       w_idle, w_s1, w_s2, w_err, w_ill, w_entry;

    assign w_code  = {fsm_o1, fsm_o2, fsm_err};
    assign w_idle  = (w_code == 3'b000);
    assign w_s1    = (w_code == 3'b100);
    assign w_s2    = (w_code == 3'b010);
    assign w_err   = (w_code == 3'b111);
    assign w_ill   = ~(w_idle | w_s1 | w_s2 | w_err);
    assign w_entry = w_err & ~prev_err_q;

    always_comb begin
        trk_d      = trk_q;
        seq_done_d = 1'b0;
        seq_viol_d = 1'b0;
        if (w_ill) begin
            trk_d = T_IDLE;
        end else if (w_err) begin
            trk_d = T_ERR;
        end else begin
            case (trk_q)
                T_IDLE: begin
                    if (w_s1) trk_d = T_S1;
                    else if (w_s2) seq_viol_d = 1'b1;
                end
                T_S1: begin
                    if (w_s2) trk_d = T_S2;
                    else if (w_idle) begin
                        seq_viol_d = 1'b1;
                        trk_d      = T_IDLE;
                    end
                end
                T_S2: begin
                    if (w_idle) begin
                        seq_done_d = 1'b1;
                        trk_d      = T_IDLE;
                    end else if (w_s1) begin
                        seq_viol_d = 1'b1;
                        trk_d      = T_IDLE;
                    end
                end
                default: begin
                    seq_viol_d = ~w_idle;
                    trk_d      = T_IDLE;
                end
            endcase
        end
    end

    // clr drops any same-cycle increment or flag set rather than deferring it
    always_comb begin
        seq_cnt_d = seq_cnt_q;
        err_cnt_d = err_cnt_q;
        consec_d  = consec_q;
        alarm_d   = alarm_q;
        illegal_d = illegal_q | w_ill;
        if (w_entry) begin
            if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
            if (!(&consec_q))  consec_d  = consec_q + 4'd1;
        end
        if (seq_done_d) begin
            if (!(&seq_cnt_q)) seq_cnt_d = seq_cnt_q + 1'b1;
            consec_d = 4'd0;
        end
        if (consec_d >= C_ERR_LIMIT) alarm_d = 1'b1;
        if (clr) begin
            seq_cnt_d = '0;
            err_cnt_d = '0;
            consec_d  = 4'd0;
            alarm_d   = 1'b0;
            illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trk_q      <= T_IDLE;
            prev_err_q <= 1'b0;
            consec_q   <= 4'd0;
            seq_cnt_q  <= '0;
            err_cnt_q  <= '0;
            alarm_q    <= 1'b0;
            illegal_q  <= 1'b0;
            seq_done_q <= 1'b0;
            seq_viol_q <= 1'b0;
        end else begin
            trk_q      <= trk_d;
            prev_err_q <= w_err;
            consec_q   <= consec_d;
            seq_cnt_q  <= seq_cnt_d;
            err_cnt_q  <= err_cnt_d;
            alarm_q    <= alarm_d;
            illegal_q  <= illegal_d;
            seq_done_q <= seq_done_d;
            seq_viol_q <= seq_viol_d;
        end
    end

    assign seq_done = seq_done_q;
    assign seq_viol = seq_viol_q;
    assign seq_cnt  = seq_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign alarm    = alarm_q;
    assign illegal  = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_event_monitor
// Purpose  : Directed plus randomized checks of fsm_event_monitor against a
//            cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_fsm_event_monitor;

    localparam int CNT_W     = 2;
    localparam int ERR_LIMIT = 3;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             fsm_o1, fsm_o2, fsm_err;
    logic             clr;
    logic             seq_done, seq_viol, alarm, illegal;
    logic [CNT_W-1:0] seq_cnt, err_cnt;

    fsm_event_monitor #(.CNT_W(CNT_W), .ERR_LIMIT(ERR_LIMIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .fsm_o1   (fsm_o1),
        .fsm_o2   (fsm_o2),
        .fsm_err  (fsm_err),
        .clr      (clr),
        .seq_done (seq_done),
        .seq_viol (seq_viol),
        .seq_cnt  (seq_cnt),
        .err_cnt  (err_cnt),
        .alarm    (alarm),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stage 0..2 = position in IDLE,S1,S2 ring, 3 = error
    int m_stage, m_prev_err, m_consec, m_seq, m_err;
    int m_done, m_viol, m_alarm, m_ill;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int code_idx(input logic [2:0] c);
        case (c)
            3'b000:  return 0;
            3'b100:  return 1;
            3'b010:  return 2;
            3'b111:  return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [2:0] idx_code(input int i);
        case (i)
            0:       return 3'b000;
            1:       return 3'b100;
            2:       return 3'b010;
            default: return 3'b111;
        endcase
    endfunction

    task automatic model_reset();
        m_stage = 0; m_prev_err = 0; m_consec = 0; m_seq = 0; m_err = 0;
        m_done = 0; m_viol = 0; m_alarm = 0; m_ill = 0;
    endtask

    task automatic model_step(input logic [2:0] c_in, input logic clr_in, input logic rst_in);
        int c, entry, bad;
        if (rst_in) begin
            model_reset();
            return;
        end
        c = code_idx(c_in);
        m_done = 0; m_viol = 0; bad = 0;
        if (c < 0) begin
            bad = 1; m_stage = 0;
        end else if (c == 3) begin
            m_stage = 3;
        end else if (m_stage == 3) begin
            m_viol = (c != 0); m_stage = 0;
        end else if (c == m_stage) begin
            m_stage = c;
        end else if (c == (m_stage + 1) % 3) begin
            m_done = (m_stage == 2);
            m_stage = c;
        end else begin
            m_viol = 1; m_stage = 0;
        end
        entry = (c == 3) && !m_prev_err;
        m_prev_err = (c == 3);
        if (clr_in) begin
            m_seq = 0; m_err = 0; m_consec = 0; m_alarm = 0; m_ill = 0;
        end else begin
            if (entry) begin
                if (m_err < CNT_MAX) m_err++;
                if (m_consec < 15) m_consec++;
                if (m_consec >= ERR_LIMIT) m_alarm = 1;
            end
            if (m_done) begin
                if (m_seq < CNT_MAX) m_seq++;
                m_consec = 0;
            end
            if (bad) m_ill = 1;
        end
    endtask

    task automatic cycle(input logic [2:0] c, input logic clr_in, input logic rst_in);
        {fsm_o1, fsm_o2, fsm_err} = c;
        clr = clr_in;
        rst = rst_in;
        @(posedge clk);
        #1;
        model_step(c, clr_in, rst_in);
        chk("seq_done", int'(seq_done), m_done);
        chk("seq_viol", int'(seq_viol), m_viol);
        chk("seq_cnt",  int'(seq_cnt),  m_seq);
        chk("err_cnt",  int'(err_cnt),  m_err);
        chk("alarm",    int'(alarm),    m_alarm);
        chk("illegal",  int'(illegal),  m_ill);
    endtask

    task automatic run_codes(input logic [2:0] cs[$]);
        foreach (cs[i]) cycle(cs[i], 1'b0, 1'b0);
    endtask

    initial begin
        logic [2:0] q[$];
        int r, nxt;
        model_reset();
        cycle(3'b000, 1'b0, 1'b1);
        cycle(3'b000, 1'b0, 1'b1);

        // one legal sequence, then the done pulse lands one cycle after 000
        q = '{3'b000, 3'b100, 3'b100, 3'b010, 3'b000};
        run_codes(q);
        chk("dir_seq_cnt", int'(seq_cnt), 1);
        cycle(3'b000, 1'b0, 1'b0);
        chk("dir_done_low", int'(seq_done), 0);

        // three error entries reach the alarm; holding error adds nothing
        q = '{3'b111, 3'b000, 3'b111, 3'b000, 3'b111, 3'b111, 3'b111, 3'b111};
        run_codes(q);
        chk("dir_alarm", int'(alarm), 1);
        chk("dir_err_hold", int'(err_cnt), 3);
        cycle(3'b000, 1'b1, 1'b0);

        // seq_done clears the consecutive count, so no alarm
        q = '{3'b111, 3'b000, 3'b111, 3'b000, 3'b100, 3'b010, 3'b000,
              3'b111, 3'b000, 3'b111, 3'b000};
        run_codes(q);
        chk("dir_no_alarm", int'(alarm), 0);

        // violations and an illegal code
        q = '{3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b101, 3'b000};
        run_codes(q);
        chk("dir_illegal", int'(illegal), 1);

        // saturation of seq_cnt, then clr in the same cycle as seq_done
        cycle(3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            q = '{3'b100, 3'b010, 3'b000};
            run_codes(q);
        end
        chk("dir_seq_sat", int'(seq_cnt), CNT_MAX);
        cycle(3'b100, 1'b0, 1'b0);
        cycle(3'b010, 1'b0, 1'b0);
        cycle(3'b000, 1'b1, 1'b0);
        chk("dir_clr_done", int'(seq_done), 1);
        chk("dir_clr_cnt",  int'(seq_cnt),  0);

        // reset while in S2 suppresses the done
        cycle(3'b100, 1'b0, 1'b0);
        cycle(3'b010, 1'b0, 1'b0);
        cycle(3'b010, 1'b0, 1'b1);
        cycle(3'b000, 1'b0, 1'b0);
        chk("dir_rst_done", int'(seq_done), 0);

        // first-cycle error after reset counts as an entry
        cycle(3'b111, 1'b0, 1'b1);
        cycle(3'b111, 1'b0, 1'b0);
        chk("dir_rst_entry", int'(err_cnt), 1);

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      nxt = (m_stage == 3) ? 0 : (m_stage + 1) % 3;
            else if (r < 75) nxt = m_stage;
            else             nxt = -1;
            if (nxt >= 0)
                q = '{idx_code(nxt)};
            else if (r < 90)
                q = '{idx_code($urandom_range(0, 3))};
            else
                q = '{3'($urandom_range(0, 7))};
            cycle(q[0], ($urandom_range(0, 99) < 2), ($urandom_range(0, 199) < 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
